arc4_encrypt: RTL

- ARC4 encryptor; the writer end of the length-prefixed message format consumed by the task3 decrypt path.
- Reads a plaintext message from a pt memory. Byte 0 is the length L; bytes 1..L are data.
- Runs the key schedule (KSA) and keystream generator (PRGA) over an external S memory.
- Writes the length-prefixed ciphertext to a ct memory. Sits beside the decrypt datapath under the task-level top and is driven by the same en/rdy handshake.

---
 rtl/arc4_pkg.sv | 29 ++
 rtl/arc4_if.sv | 25 ++
 rtl/arc4_ksa.sv | 79 +++++++
 rtl/arc4_encrypt.sv | 102 ++++++++++
 4 files changed

// File: rtl/arc4_pkg.sv
// Shared types and helpers for the ARC4 encrypt datapath.
//   state_t      : top-level phase (IDLE, INIT, KSA, LEN, PRGA, DONE)
//   ksa_step_t   : per-iteration sub-steps of the key schedule
//   enc_step_t   : sub-steps of LEN and PRGA in the encryptor
//   keybyte()    : big-endian key byte select, byte n = key[KEY_W-1-8*(n%3) -: 8]
package arc4_pkg;
  localparam int unsigned KEY_W     = 24;
  localparam int unsigned KEY_BYTES = 3;
  localparam int unsigned MEM_DEPTH = 256;

  typedef enum logic [2:0] {IDLE, INIT, KSA, LEN, PRGA, DONE} state_t;

  typedef enum logic [2:0] {K_RDI, K_WAITI, K_GETI, K_WAITJ, K_GETJ, K_WRI} ksa_step_t;

  typedef enum logic [3:0] {
    L_GET, L_HOLD,
    P_RDI, P_WAITI, P_GETI, P_WAITJ, P_GETJ, P_WRI, P_RDP, P_WAITP, P_OUT, P_TAIL
  } enc_step_t;

  function automatic logic [7:0] keybyte(input logic [KEY_W-1:0] key, input logic [7:0] idx);
    logic [7:0] n;
    n = idx % 8'(KEY_BYTES);
    case (n)
      8'd0:    return key[KEY_W-1 -: 8];
      8'd1:    return key[KEY_W-9 -: 8];
      default: return key[KEY_W-17 -: 8];
    endcase
  endfunction
endpackage

// File: rtl/arc4_if.sv
// Handshake and memory-port bundle of the ARC4 encryptor.
//   en/rdy/key          : start handshake and key
//   pt_addr/pt_rddata   : plaintext read port (1-cycle read latency)
//   ct_addr/ct_wrdata/ct_wren : ciphertext write port
//   s_addr/s_rddata/s_wrdata/s_wren : S memory port (1-cycle read latency)
// slave = the encryptor, master = the surrounding system / memories.
interface arc4_if;
  import arc4_pkg::*;
  logic             en, rdy;
  logic [KEY_W-1:0] key;
  logic [7:0]       pt_addr, pt_rddata;
  logic [7:0]       ct_addr, ct_wrdata;
  logic             ct_wren;
  logic [7:0]       s_addr, s_rddata, s_wrdata;
  logic             s_wren;

  modport master (
    output en, key, pt_rddata, s_rddata,
    input  rdy, pt_addr, ct_addr, ct_wrdata, ct_wren, s_addr, s_wrdata, s_wren
  );
  modport slave (
    input  en, key, pt_rddata, s_rddata,
    output rdy, pt_addr, ct_addr, ct_wrdata, ct_wren, s_addr, s_wrdata, s_wren
  );
endinterface

// File: rtl/arc4_ksa.sv
// ARC4 S-box initialisation (s[i]=i) followed by the key schedule, over a
// single-port S memory with 1-cycle read latency.
//   clk, rst_n : clock, synchronous active-low reset
//   en, rdy    : start pulse (taken while rdy=1), idle flag
//   key        : captured when en is accepted
//   phase      : current phase (IDLE/INIT/KSA/DONE) for the sequencing top
//   s_*        : S memory port, registered outputs
module arc4_ksa
  import arc4_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [KEY_W-1:0] key,
  output logic             rdy,
  output state_t           phase,
  output logic [7:0]       s_addr,
  input  logic [7:0]       s_rddata,
  output logic [7:0]       s_wrdata,
  output logic             s_wren
);
  localparam logic [7:0] LAST = 8'(MEM_DEPTH - 1);

  state_t           state, state_n;
  ksa_step_t        step, step_n;
  logic [KEY_W-1:0] key_q, key_n;
  logic [7:0]       i, i_n, j, j_n, si, si_n, sj, sj_n, addr_q, addr_n, wdata_q, wdata_n, jsum;
  logic             wren_q, wren_n;

  assign rdy      = (state == IDLE);
  assign phase    = state;
  assign s_addr   = addr_q;
  assign s_wrdata = wdata_q;
  assign s_wren   = wren_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;  step <= K_RDI;  key_q <= '0;
      i <= '0;  j <= '0;  si <= '0;  sj <= '0;
      addr_q <= '0;  wdata_q <= '0;  wren_q <= 1'b0;
    end else begin
      state <= state_n;  step <= step_n;  key_q <= key_n;
      i <= i_n;  j <= j_n;  si <= si_n;  sj <= sj_n;
      addr_q <= addr_n;  wdata_q <= wdata_n;  wren_q <= wren_n;
    end
  end

  // Each swap reads s[i] then s[j] before writing either, so i==j simply
  // writes the same value back twice and never sees stale data.
  always_comb begin
    state_n = state;  step_n = step;  key_n = key_q;
    i_n = i;  j_n = j;  si_n = si;  sj_n = sj;
    addr_n = addr_q;  wdata_n = wdata_q;  wren_n = 1'b0;
    jsum = j + s_rddata + keybyte(key_q, i);
    case (state)
      IDLE: if (en) begin
        state_n = INIT;  step_n = K_RDI;  key_n = key;  i_n = '0;  j_n = '0;
      end
      INIT: begin
        addr_n = i;  wdata_n = i;  wren_n = 1'b1;  i_n = i + 8'd1;
        if (i == LAST) state_n = KSA;
      end
      KSA: case (step)
        K_RDI:   begin addr_n = i;  step_n = K_WAITI; end
        K_WAITI: step_n = K_GETI;
        K_GETI:  begin si_n = s_rddata;  j_n = jsum;  addr_n = jsum;  step_n = K_WAITJ; end
        K_WAITJ: step_n = K_GETJ;
        K_GETJ:  begin sj_n = s_rddata;  addr_n = j;  wdata_n = si;  wren_n = 1'b1;  step_n = K_WRI; end
        K_WRI: begin
          addr_n = i;  wdata_n = sj;  wren_n = 1'b1;  i_n = i + 8'd1;  step_n = K_RDI;
          if (i == LAST) state_n = DONE;
        end
        default: step_n = K_RDI;
      endcase
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: reads length-prefixed plaintext (pt[0]=L, pt[1..L]), runs
// INIT+KSA through arc4_ksa, then writes ct[0]=L and ct[k]=pt[k]^pad for k=1..L.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : arc4_if.slave (en/rdy/key handshake, pt, ct and S memory ports)
module arc4_encrypt
  import arc4_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  arc4_if.slave bus
);
  state_t    state, state_n, ksa_phase;
  enc_step_t step, step_n;
  logic [7:0] i, i_n, j, j_n, k, k_n, len, len_n, si, si_n, sj, sj_n, ptb, ptb_n, jsum;
  logic [7:0] pt_addr_q, pt_addr_n, ct_addr_q, ct_addr_n, ct_wdata_q, ct_wdata_n;
  logic [7:0] s_addr_q, s_addr_n, s_wdata_q, s_wdata_n, ksa_s_addr, ksa_s_wdata;
  logic       ct_wren_q, ct_wren_n, s_wren_q, s_wren_n, ksa_s_wren, ksa_rdy, start, ksa_sel;

  assign start   = (state == IDLE) && bus.en && ksa_rdy;
  assign ksa_sel = (state == INIT) || (state == KSA);

  arc4_ksa u_ksa (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (start),
    .key      (bus.key),
    .rdy      (ksa_rdy),
    .phase    (ksa_phase),
    .s_addr   (ksa_s_addr),
    .s_rddata (bus.s_rddata),
    .s_wrdata (ksa_s_wdata),
    .s_wren   (ksa_s_wren)
  );

  assign bus.rdy       = (state == IDLE);
  assign bus.pt_addr   = pt_addr_q;
  assign bus.ct_addr   = ct_addr_q;
  assign bus.ct_wrdata = ct_wdata_q;
  assign bus.ct_wren   = ct_wren_q;
  assign bus.s_addr    = ksa_sel ? ksa_s_addr  : s_addr_q;
  assign bus.s_wrdata  = ksa_sel ? ksa_s_wdata : s_wdata_q;
  assign bus.s_wren    = ksa_sel ? ksa_s_wren  : s_wren_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;  step <= L_GET;
      i <= '0;  j <= '0;  k <= '0;  len <= '0;  si <= '0;  sj <= '0;  ptb <= '0;
      pt_addr_q <= '0;  ct_addr_q <= '0;  ct_wdata_q <= '0;  ct_wren_q <= 1'b0;
      s_addr_q <= '0;  s_wdata_q <= '0;  s_wren_q <= 1'b0;
    end else begin
      state <= state_n;  step <= step_n;
      i <= i_n;  j <= j_n;  k <= k_n;  len <= len_n;  si <= si_n;  sj <= sj_n;  ptb <= ptb_n;
      pt_addr_q <= pt_addr_n;  ct_addr_q <= ct_addr_n;  ct_wdata_q <= ct_wdata_n;  ct_wren_q <= ct_wren_n;
      s_addr_q <= s_addr_n;  s_wdata_q <= s_wdata_n;  s_wren_q <= s_wren_n;
    end
  end

  // Outputs are registered, so a write issued in one step is on the bus during
  // the next; L_HOLD and P_TAIL keep that cycle inside LEN/PRGA. pt_addr is
  // parked at 0 on acceptance so L is already on pt_rddata when LEN begins.
  always_comb begin
    state_n = state;  step_n = step;
    i_n = i;  j_n = j;  k_n = k;  len_n = len;  si_n = si;  sj_n = sj;  ptb_n = ptb;
    pt_addr_n = pt_addr_q;  ct_addr_n = ct_addr_q;  ct_wdata_n = ct_wdata_q;  ct_wren_n = 1'b0;
    s_addr_n = s_addr_q;  s_wdata_n = s_wdata_q;  s_wren_n = 1'b0;
    jsum = j + bus.s_rddata;
    case (state)
      IDLE: if (start) begin state_n = INIT;  pt_addr_n = '0; end
      INIT: if (ksa_phase == KSA) state_n = KSA;
      KSA:  if (ksa_phase == DONE) begin state_n = LEN;  step_n = L_GET; end
      LEN: case (step)
        L_GET: begin
          len_n = bus.pt_rddata;  ct_addr_n = '0;  ct_wdata_n = bus.pt_rddata;  ct_wren_n = 1'b1;
          i_n = '0;  j_n = '0;  k_n = 8'd1;  step_n = L_HOLD;
        end
        default: begin
          if (len == 8'd0) state_n = DONE;
          else begin state_n = PRGA;  step_n = P_RDI; end
        end
      endcase
      PRGA: case (step)
        P_RDI:   begin i_n = i + 8'd1;  s_addr_n = i + 8'd1;  pt_addr_n = k;  step_n = P_WAITI; end
        P_WAITI: step_n = P_GETI;
        P_GETI:  begin si_n = bus.s_rddata;  ptb_n = bus.pt_rddata;  j_n = jsum;  s_addr_n = jsum;  step_n = P_WAITJ; end
        P_WAITJ: step_n = P_GETJ;
        P_GETJ:  begin sj_n = bus.s_rddata;  s_addr_n = j;  s_wdata_n = si;  s_wren_n = 1'b1;  step_n = P_WRI; end
        P_WRI:   begin s_addr_n = i;  s_wdata_n = sj;  s_wren_n = 1'b1;  step_n = P_RDP; end
        P_RDP:   begin s_addr_n = si + sj;  step_n = P_WAITP; end
        P_WAITP: step_n = P_OUT;
        P_OUT: begin
          ct_addr_n = k;  ct_wdata_n = ptb ^ bus.s_rddata;  ct_wren_n = 1'b1;
          // Stop on k==len before incrementing so L=255 never wraps k to 0.
          if (k == len) step_n = P_TAIL;
          else begin k_n = k + 8'd1;  step_n = P_RDI; end
        end
        default: state_n = DONE;
      endcase
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule
